// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional performance counters in ifu_fetch are enabled with IFU_PERF_CNT_EN.
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // One fetched instruction together with the byte PC it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small circular buffer between the imem response and decode.
// The head is read straight from storage registers, so it stays stable while
// the consumer stalls. A flush empties the buffer in one cycle.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               flush_i,
    input  logic               push_i,
    input  fetch_entry_t       push_data_i,
    input  logic               pop_i,
    output fetch_entry_t       head_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);

    fetch_entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]        rdPtr_q;
    logic [PTR_W-1:0]        wrPtr_q;
    logic [CNT_W-1:0]        count_q;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy; flush beats any push or pop.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wrPtr_q] <= push_data_i;
                wrPtr_q        <= nextPtr(wrPtr_q);
            end
            if (pop_i) begin
                rdPtr_q <= nextPtr(rdPtr_q);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, drives the synchronous imem, captures
// the response one cycle later and hands {pc, inst} to decode.
// A redirect flushes buffered and in-flight fetches and restarts at the target.
// Define IFU_PERF_CNT_EN to add the perf_fetched / perf_bubbles counters.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 16,
    parameter int          DEPTH    = 2
) (
    input  logic              clock,
    input  logic              resetn,
    output logic [ADDR_W-1:0] imem_address,
    output logic [31:0]       imem_data,
    output logic              imem_wren,
    input  logic [31:0]       imem_q,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic             inflight_q;
    logic [31:0]      inflightPc_q;

    logic             deq;
    logic             issue;
    logic             fifoPush;
    logic [31:0]      occupancy;
    logic [31:0]      redirectTarget;
    fetch_entry_t     fifoHead;
    fetch_entry_t     fifoIn;
    logic [CNT_W-1:0] fifoCount;
    logic             fifoFull;
    logic             fifoEmpty;

    assign redirectTarget = redirect_pc & 32'hFFFF_FFFC;

    // Decode may not take anything in the redirect cycle: the head is stale.
    assign inst_valid = !fifoEmpty && !redirect_valid;
    assign deq        = inst_valid && inst_ready;

    // Only fetch when the buffer is guaranteed a free slot for the response.
    assign occupancy  = 32'(fifoCount) + 32'(inflight_q) - 32'(deq);
    assign issue      = !redirect_valid && (occupancy < 32'(DEPTH));
    assign fifoPush   = inflight_q && !redirect_valid && (!fifoFull || deq);
    assign fifoIn     = '{pc: inflightPc_q, inst: imem_q};

    // Next PC: redirect target wins, otherwise advance on each issued fetch.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirectTarget;
        end else if (issue) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // PC and in-flight tracking for the one-cycle imem read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc_q         <= RESET_PC;
            inflight_q   <= 1'b0;
            inflightPc_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) begin
                inflightPc_q <= pc_q;
            end
        end
    end

    ifu_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock       (clock),
        .resetn      (resetn),
        .flush_i     (redirect_valid),
        .push_i      (fifoPush),
        .push_data_i (fifoIn),
        .pop_i       (deq),
        .head_o      (fifoHead),
        .count_o     (fifoCount),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty)
    );

    assign imem_address = pc_q[ADDR_W+1:2];
    assign imem_data    = 32'h0;
    assign imem_wren    = 1'b0;
    assign inst         = fifoHead.inst;
    assign inst_pc      = fifoHead.pc;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perfFetched_q;
    logic [31:0] perfBubbles_q;

    // Saturating counters for accepted transfers and starved decode cycles.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            perfFetched_q <= '0;
            perfBubbles_q <= '0;
        end else begin
            if (deq && (perfFetched_q != 32'hFFFF_FFFF)) begin
                perfFetched_q <= perfFetched_q + 32'd1;
            end
            if (inst_ready && !inst_valid && (perfBubbles_q != 32'hFFFF_FFFF)) begin
                perfBubbles_q <= perfBubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perfFetched_q;
    assign perf_bubbles = perfBubbles_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: the stimulus process queues each expected
// {cycle, pc, inst} transfer, a negedge monitor pops and compares on every
// accepted transfer. imem is modelled as mem[i] = i with one-cycle read latency.
module tb_ifu_fetch;

    logic        clock = 1'b0;
    logic        resetn;
    logic [15:0] imem_address;
    logic [31:0] imem_data;
    logic        imem_wren;
    logic [31:0] imem_q;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    typedef struct {
        int          cycle;
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monExp;
    logic [31:0] mem [0:65535];
    int          cyc = 0;
    int          c0 = 0;
    int          checks = 0;
    int          errors = 0;

    ifu_fetch #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (16),
        .DEPTH    (2)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .imem_address   (imem_address),
        .imem_data      (imem_data),
        .imem_wren      (imem_wren),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    // Cycle counter used to timestamp expected transfers.
    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous-read instruction memory model.
    always @(posedge clock) imem_q <= mem[imem_address];

    // Monitor: every accepted transfer must match the head of the expected queue.
    always @(negedge clock) begin
        if (resetn && inst_valid && inst_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_transfer: got pc=%h inst=%h at cycle %0d, expected no transfer",
                         inst_pc, inst, cyc - c0);
            end else begin
                monExp = expQ.pop_front();
                if (inst_pc !== monExp.pc || inst !== monExp.inst || cyc !== monExp.cycle) begin
                    errors++;
                    $display("[TB] FAIL transfer: got pc=%h inst=%h cycle=%0d, expected pc=%h inst=%h cycle=%0d",
                             inst_pc, inst, cyc - c0, monExp.pc, monExp.inst, monExp.cycle - c0);
                end
            end
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic waitRel(input int rel);
        while (cyc - c0 < rel) tick();
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Queue n consecutive transfers starting at relative cycle startRel.
    task automatic expectStream(input int startRel, input logic [31:0] startPc, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cycle = c0 + startRel + i;
            e.pc    = startPc + 32'(4 * i);
            e.inst  = (e.pc >> 2) & 32'h0000_FFFF;
            expQ.push_back(e);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'(i);
        applyStimulus(1'b0, 32'h0, 1'b1);
        resetn = 1'b1;
        #1 resetn = 1'b0;
        tick();
        tick();
        checkOutput("reset_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("reset_inst", inst, 32'h0);
        checkOutput("reset_inst_pc", inst_pc, 32'h0);
        checkOutput("reset_address", 32'(imem_address), 32'h0);
        checkOutput("imem_wren", 32'(imem_wren), 32'h0);
        checkOutput("imem_data", imem_data, 32'h0);

        // Run 1: stream, stall, redirects, address wrap.
        resetn = 1'b1;
        c0 = cyc;
        expectStream(2, 32'h0000_0000, 3);
        expectStream(15, 32'h0000_000C, 5);
        expectStream(23, 32'h0000_0100, 3);
        expectStream(30, 32'h0000_0080, 3);
        expectStream(36, 32'h0003_FFFC, 4);

        checkOutput("addr_cycle0", 32'(imem_address), 32'h0);
        waitRel(1);
        checkOutput("addr_cycle1", 32'(imem_address), 32'h1);

        waitRel(5);
        applyStimulus(1'b0, 32'h0, 1'b0);
        waitRel(8);
        checkOutput("stall_addr_c8", 32'(imem_address), 32'h5);
        checkOutput("stall_valid_c8", 32'(inst_valid), 32'h1);
        checkOutput("stall_pc_c8", inst_pc, 32'h0000_000C);
        waitRel(14);
        checkOutput("stall_addr_c14", 32'(imem_address), 32'h5);
        checkOutput("stall_pc_c14", inst_pc, 32'h0000_000C);
        checkOutput("stall_inst_c14", inst, 32'h3);
        waitRel(15);
        applyStimulus(1'b0, 32'h0, 1'b1);

        waitRel(20);
        applyStimulus(1'b1, 32'h0000_0103, 1'b1);
        #1;
        checkOutput("redirect_valid_low", 32'(inst_valid), 32'h0);
        waitRel(21);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("redirect_addr", 32'(imem_address), 32'h40);

        waitRel(26);
        applyStimulus(1'b1, 32'h0000_0040, 1'b1);
        waitRel(27);
        applyStimulus(1'b1, 32'h0000_0080, 1'b1);
        waitRel(28);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("b2b_redirect_addr", 32'(imem_address), 32'h20);

        waitRel(33);
        applyStimulus(1'b1, 32'h0003_FFFC, 1'b1);
        waitRel(34);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("wrap_addr_hi", 32'(imem_address), 32'hFFFF);
        waitRel(35);
        checkOutput("wrap_addr_lo", 32'(imem_address), 32'h0);

        waitRel(40);
`ifdef IFU_PERF_CNT_EN
        checkOutput("perf_fetched_run1", perf_fetched, 32'd18);
        checkOutput("perf_bubbles_run1", perf_bubbles, 32'd12);
`endif
        resetn = 1'b0;
        #1;
        checkOutput("midrun_reset_valid", 32'(inst_valid), 32'h0);
        checkOutput("midrun_reset_addr", 32'(imem_address), 32'h0);
        checkOutput("midrun_reset_pc", inst_pc, 32'h0);
        tick();
        tick();

        // Run 2: restart from the reset PC.
        resetn = 1'b1;
        c0 = cyc;
`ifdef IFU_PERF_CNT_EN
        checkOutput("perf_fetched_reset", perf_fetched, 32'h0);
        checkOutput("perf_bubbles_reset", perf_bubbles, 32'h0);
`endif
        expectStream(2, 32'h0000_0000, 6);
        waitRel(8);
        applyStimulus(1'b0, 32'h0, 1'b0);
        waitRel(12);

        checkOutput("pending_expected", 32'(expQ.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
